// File: rtl/apb_timer_pkg.sv
// Shared register-map constants, TCR bit positions and the per-channel control struct
// used by apb_timer_mc and its channels.
package apb_timer_pkg;

    localparam logic [3:0] OFF_TCR  = 4'h0;
    localparam logic [3:0] OFF_TCNT = 4'h4;
    localparam logic [3:0] OFF_PSC  = 4'h8;
    localparam logic [3:0] OFF_ARR  = 4'hC;

    localparam int TCR_EN      = 0;
    localparam int TCR_CLR     = 1;
    localparam int TCR_ONESHOT = 2;
    localparam int TCR_IE      = 3;

    typedef struct packed {
        logic ie;
        logic oneshot;
        logic en;
    } tcr_t;

    function automatic int isr_base(input int num_ch);
        return num_ch * 16;
    endfunction

    // CLR is a write-only strobe, so its bit always reads back as 0.
    function automatic logic [31:0] tcr_word(input tcr_t t);
        logic [31:0] w;
        w              = '0;
        w[TCR_EN]      = t.en;
        w[TCR_ONESHOT] = t.oneshot;
        w[TCR_IE]      = t.ie;
        return w;
    endfunction

endpackage

// File: rtl/apb_timer_mc_channel.sv
// One timer channel: prescaler, registered tick, auto-reload up-counter,
// wrap pulse and the one-shot EN clear request.
module timer_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             oneshot_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] psc_i,
    input  logic [CNT_W-1:0] arr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             en_clr_o
);

    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap   = 1'b0;
        if (load_i) begin
            cnt_d  = load_val_i;
            pcnt_d = '0;
        end else if (clr_i) begin
            cnt_d  = '0;
            pcnt_d = '0;
        end else if (en_i) begin
            if (pcnt_q == psc_i) begin
                pcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + CNT_W'(1);
            end
            // A tick left over from the wrap that stopped a one-shot is dropped with EN low.
            if (tick_q) begin
                if (cnt_q == arr_i) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst_i) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = wrap;
    assign en_clr_o = wrap & oneshot_i;

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: APB decode, register file, IF/ISR and irq around NUM_CH timer_channel
// instances. Define TIMER_IRQ_EN to build the interrupt flags, ISR, IE bit and irq output.
module apb_timer_mc
    import apb_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = $clog2(NUM_CH + 1) + 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              irq
);

    localparam int IDX_W    = ADDR_W - 4;
    localparam int ISR_ADDR = isr_base(NUM_CH);
`ifdef TIMER_IRQ_EN
    localparam logic HAS_IRQ = 1'b1;
`else
    localparam logic HAS_IRQ = 1'b0;
`endif

    logic [IDX_W-1:0] idx;
    logic [3:0]       off;
    logic             access, wr_en, rd_en, isr_hit;
    logic             pready_q;
    logic [31:0]      prdata_q, rdata_sel, isr_word;

    tcr_t             tcr_q [NUM_CH];
    tcr_t             tcr_d [NUM_CH];
    logic [CNT_W-1:0] psc_q [NUM_CH];
    logic [CNT_W-1:0] psc_d [NUM_CH];
    logic [CNT_W-1:0] arr_q [NUM_CH];
    logic [CNT_W-1:0] arr_d [NUM_CH];
    logic [CNT_W-1:0] cnt   [NUM_CH];
    logic [NUM_CH-1:0] load, clr, wrap, en_clr;
    logic             unused_bits;

    assign idx     = PADDR[ADDR_W-1:4];
    assign off     = {PADDR[3:2], 2'b00};
    // Only the first access cycle acts; the registered PREADY blocks a second commit.
    assign access  = PSEL & PENABLE & ~pready_q;
    assign wr_en   = access & PWRITE;
    assign rd_en   = access & ~PWRITE;
    assign isr_hit = ({idx, off} == ADDR_W'(ISR_ADDR));

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tcr_d[ch] = tcr_q[ch];
            psc_d[ch] = psc_q[ch];
            arr_d[ch] = arr_q[ch];
            load[ch]  = 1'b0;
            clr[ch]   = 1'b0;
            if (en_clr[ch]) tcr_d[ch].en = 1'b0;
            if (wr_en && idx == IDX_W'(ch)) begin
                case (off)
                    OFF_TCR: begin
                        tcr_d[ch].en      = PWDATA[TCR_EN];
                        tcr_d[ch].oneshot = PWDATA[TCR_ONESHOT];
                        tcr_d[ch].ie      = HAS_IRQ & PWDATA[TCR_IE];
                        clr[ch]           = PWDATA[TCR_CLR];
                    end
                    OFF_TCNT: load[ch]  = 1'b1;
                    OFF_PSC:  psc_d[ch] = PWDATA[CNT_W-1:0];
                    OFF_ARR:  arr_d[ch] = PWDATA[CNT_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_sel = isr_hit ? isr_word : '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (idx == IDX_W'(ch)) begin
                case (off)
                    OFF_TCR:  rdata_sel = tcr_word(tcr_q[ch]);
                    OFF_TCNT: rdata_sel = 32'(cnt[ch]);
                    OFF_PSC:  rdata_sel = 32'(psc_q[ch]);
                    OFF_ARR:  rdata_sel = 32'(arr_q[ch]);
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_q <= 1'b0;
            prdata_q <= '0;
            // NOTE: the register file is a handful of flops with defined reset values, not a RAM, so it is reset.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                tcr_q[ch] <= '0;
                psc_q[ch] <= '0;
                arr_q[ch] <= '1;
            end
        end else begin
            pready_q <= access;
            if (rd_en) prdata_q <= rdata_sel;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                tcr_q[ch] <= tcr_d[ch];
                psc_q[ch] <= psc_d[ch];
                arr_q[ch] <= arr_d[ch];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i      (PCLK),
            .rst_i      (PRESET),
            .en_i       (tcr_q[g].en),
            .oneshot_i  (tcr_q[g].oneshot),
            .clr_i      (clr[g]),
            .load_i     (load[g]),
            .load_val_i (PWDATA[CNT_W-1:0]),
            .psc_i      (psc_q[g]),
            .arr_i      (arr_q[g]),
            .cnt_o      (cnt[g]),
            .wrap_o     (wrap[g]),
            .en_clr_o   (en_clr[g])
        );
    end

`ifdef TIMER_IRQ_EN
    logic [NUM_CH-1:0] if_q, if_d, w1c, ie_vec;
    logic              irq_q;

    // A wrap in the same cycle as a W1C of its bit keeps the flag set.
    assign w1c  = (wr_en && isr_hit) ? PWDATA[NUM_CH-1:0] : '0;
    assign if_d = (if_q & ~w1c) | wrap;

    always_comb begin
        ie_vec = '0;
        for (int ch = 0; ch < NUM_CH; ch++) ie_vec[ch] = tcr_q[ch].ie;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            if_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if_q  <= if_d;
            irq_q <= |(if_q & ie_vec);
        end
    end

    assign isr_word = 32'(if_q);
    assign irq      = irq_q;
`else
    assign isr_word = '0;
    assign irq      = 1'b0;
`endif

    assign unused_bits = ^{PADDR[1:0], wrap};
    assign PRDATA      = prdata_q;
    assign PREADY      = pready_q;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed bench for apb_timer_mc (NUM_CH=2, CNT_W=32); expectations follow TIMER_IRQ_EN.
module tb_apb_timer_mc;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;
    localparam int AW     = $clog2(NUM_CH + 1) + 4;
`ifdef TIMER_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    localparam logic [AW-1:0] A_TCR0  = AW'(6'h00);
    localparam logic [AW-1:0] A_TCNT0 = AW'(6'h04);
    localparam logic [AW-1:0] A_PSC0  = AW'(6'h08);
    localparam logic [AW-1:0] A_ARR0  = AW'(6'h0C);
    localparam logic [AW-1:0] A_TCR1  = AW'(6'h10);
    localparam logic [AW-1:0] A_TCNT1 = AW'(6'h14);
    localparam logic [AW-1:0] A_PSC1  = AW'(6'h18);
    localparam logic [AW-1:0] A_ARR1  = AW'(6'h1C);
    localparam logic [AW-1:0] A_ISR   = AW'(6'h20);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = '0;
    logic          pwrite = 1'b0;
    logic          penable = 1'b0;
    logic          psel = 1'b0;
    logic [31:0]   prdata;
    logic          pready;
    logic          irq;

    int errors = 0;
    int checks = 0;

    apb_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PWRITE  (pwrite),
        .PENABLE (penable),
        .PSEL    (psel),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Setup cycle, access cycle, then wait (bounded) for PREADY; returns 1 time unit after the commit edge.
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        psel    = 1'b1;
        penable = 1'b0;
        step(1);
        penable = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (pready !== 1'b1 && n < 8);
        checks++;
        if (pready !== 1'b1) begin
            errors++;
            $display("FAIL apb_pready_timeout addr=%h got=%b exp=1", addr, pready);
        end
        rdata   = prdata;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb_xfer(addr, 1'b1, data, dummy);
    endtask

    task automatic apb_read(input logic [AW-1:0] addr, output logic [31:0] data);
        apb_xfer(addr, 1'b0, 32'h0, data);
    endtask

    task automatic test_reset;
        logic [AW-1:0] addrs [11];
        logic [31:0]   exps  [11];
        logic [31:0]   d;
        addrs = '{A_TCR0, A_TCNT0, A_PSC0, A_ARR0, A_TCR1, A_TCNT1, A_PSC1, A_ARR1, A_ISR,
                  AW'(6'h24), AW'(6'h3C)};
        exps  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0,
                  32'h0, 32'h0};
        rst = 1'b1;
        step(3);
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got pready=%b prdata=%h irq=%b exp 0/0/0", pready, prdata, irq);
        end
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 11; i++) begin
            apb_read(addrs[i], d);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], d, exps[i]);
            end
        end
        step(1);
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL pready_single_cycle got=%b exp=0", pready);
        end
        apb_write(AW'(6'h30), 32'hDEAD_BEEF);
        apb_read(AW'(6'h30), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got=%h exp=0", d);
        end
    endtask

    task automatic test_periodic;
        logic [31:0] d;
        logic [31:0] exp_cnt [5];
        logic        e;
        exp_cnt = '{32'd2, 32'd3, 32'd3, 32'd0, 32'd1};
        apb_write(A_PSC0, 32'd2);
        apb_write(A_ARR0, 32'd3);
        apb_write(A_TCR0, 32'h9);
        // IF[0] sets 13 edges after the enable commit; irq follows one edge later.
        for (int k = 1; k <= 14; k++) begin
            step(1);
            e = IRQ && (k == 14);
            checks++;
            if (irq !== e) begin
                errors++;
                $display("FAIL periodic_irq cycle=%0d got=%b exp=%b", k, irq, e);
            end
        end
        apb_read(A_ISR, d);
        checks++;
        if (d !== (IRQ ? 32'h1 : 32'h0)) begin
            errors++;
            $display("FAIL periodic_isr got=%h exp=%h", d, IRQ ? 32'h1 : 32'h0);
        end
        apb_write(A_ISR, 32'h1);
        checks++;
        if (irq !== IRQ) begin
            errors++;
            $display("FAIL irq_before_drop got=%b exp=%b", irq, IRQ);
        end
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_w1c got=%b exp=0", irq);
        end
        for (int i = 0; i < 5; i++) begin
            apb_read(A_TCNT0, d);
            checks++;
            if (d !== exp_cnt[i]) begin
                errors++;
                $display("FAIL periodic_cnt idx=%0d got=%h exp=%h", i, d, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic [31:0] exp_cnt [4];
        exp_cnt = '{32'd0, 32'd2, 32'd4, 32'd0};
        apb_write(A_PSC1, 32'd0);
        apb_write(A_ARR1, 32'd4);
        apb_write(A_TCR1, 32'h5);
        for (int i = 0; i < 4; i++) begin
            apb_read(A_TCNT1, d);
            checks++;
            if (d !== exp_cnt[i]) begin
                errors++;
                $display("FAIL oneshot_cnt idx=%0d got=%h exp=%h", i, d, exp_cnt[i]);
            end
        end
        apb_read(A_TCR1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL oneshot_en_clear got=%h exp=4", d);
        end
        apb_read(A_TCNT1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_cnt_hold got=%h exp=0", d);
        end
        apb_read(A_ISR, d);
        checks++;
        if (d !== (IRQ ? 32'h3 : 32'h0)) begin
            errors++;
            $display("FAIL oneshot_isr got=%h exp=%h", d, IRQ ? 32'h3 : 32'h0);
        end
        apb_read(A_TCR0, d);
        checks++;
        if (d !== (IRQ ? 32'h9 : 32'h1)) begin
            errors++;
            $display("FAIL ch0_unaffected got=%h exp=%h", d, IRQ ? 32'h9 : 32'h1);
        end
        checks++;
        if (irq !== IRQ) begin
            errors++;
            $display("FAIL ch0_irq_level got=%b exp=%b", irq, IRQ);
        end
        apb_write(A_TCR0, 32'h0);
        apb_write(A_ISR, 32'h3);
        apb_read(A_ISR, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL isr_cleared got=%h exp=0", d);
        end
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_cleared got=%b exp=0", irq);
        end
    endtask

    task automatic test_load_clear;
        logic [31:0] d;
        apb_write(A_PSC0, 32'd1);
        apb_write(A_ARR0, 32'd100);
        apb_write(A_TCR0, 32'h1);
        apb_write(A_TCNT0, 32'd7);
        apb_read(A_TCNT0, d);
        checks++;
        if (d !== 32'd7) begin
            errors++;
            $display("FAIL tcnt_load got=%h exp=7", d);
        end
        apb_write(A_TCR0, 32'h3);
        apb_read(A_TCNT0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clr_cnt got=%h exp=0", d);
        end
        apb_read(A_TCR0, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL clr_reads_zero got=%h exp=1", d);
        end
        apb_read(A_TCNT0, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL count_after_clr got=%h exp=2", d);
        end
        apb_write(A_TCR0, 32'h0);
    endtask

    task automatic test_collisions;
        logic [31:0] d;
        // One-shot with ARR=0 wraps exactly on the commit edge of the following ISR write.
        apb_write(A_ARR1, 32'd0);
        apb_write(A_TCR1, 32'h5);
        apb_write(A_ISR, 32'h2);
        apb_read(A_ISR, d);
        checks++;
        if (d !== (IRQ ? 32'h2 : 32'h0)) begin
            errors++;
            $display("FAIL w1c_vs_wrap got=%h exp=%h", d, IRQ ? 32'h2 : 32'h0);
        end
        apb_read(A_TCR1, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL collision_oneshot_tcr got=%h exp=4", d);
        end
        apb_write(A_ISR, 32'h2);
        apb_read(A_ISR, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_plain got=%h exp=0", d);
        end
        // With PSC=0 every cycle carries a tick, so the TCNT commit lands on one.
        apb_write(A_ARR1, 32'd1000);
        apb_write(A_TCR1, 32'h1);
        apb_write(A_TCNT1, 32'h50);
        apb_read(A_TCNT1, d);
        checks++;
        if (d !== 32'h50) begin
            errors++;
            $display("FAIL load_vs_tick got=%h exp=50", d);
        end
        apb_read(A_TCNT1, d);
        checks++;
        if (d !== 32'h52) begin
            errors++;
            $display("FAIL count_after_load got=%h exp=52", d);
        end
        apb_write(A_TCR1, 32'h0);
    endtask

    task automatic test_preset_mid;
        logic [31:0] d;
        apb_write(A_PSC0, 32'd3);
        apb_write(A_TCR1, 32'h5);
        paddr   = A_PSC0;
        pwdata  = 32'd5;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        step(1);
        penable = 1'b1;
        rst     = 1'b1;
        step(1);
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL preset_pready got=%b exp=0", pready);
        end
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        rst     = 1'b0;
        step(1);
        apb_read(A_PSC0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL preset_psc got=%h exp=0", d);
        end
        apb_read(A_ARR0, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL preset_arr got=%h exp=ffffffff", d);
        end
        apb_read(A_TCR1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL preset_tcr got=%h exp=0", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL preset_irq got=%b exp=0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_load_clear();
        test_collisions();
        test_preset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_timer_mc.md
# apb_timer_mc

Multi-channel APB timer peripheral: NUM_CH independent prescaled up-counters, each with its own control, count, prescale and auto-reload registers. Each channel adds one-shot mode, software counter load, and a wrap interrupt with a shared write-1-to-clear status register. It sits on the APB bus as a single slave in place of the single-channel timer, and drives one level interrupt line to the interrupt controller.

## Interface
- NUM_CH, 2: number of timer channels (1..8).
- CNT_W, 32: prescaler and counter width (8..32). Register reads are zero-extended; writes are truncated to CNT_W.
- ADDR_W, derived as $clog2(NUM_CH+1)+4: PADDR width. Not to be overridden.
- PCLK, in, 1: the only clock.
- PRESET, in, 1: synchronous, active-high reset.
- PADDR, in, ADDR_W: byte address. Bits [1:0] are ignored.
- PWDATA, in, 32: write data.
- PWRITE, in, 1: 1 = write.
- PENABLE, in, 1: APB access phase.
- PSEL, in, 1: slave select.
- PRDATA, out, 32: read data, registered.
- PREADY, out, 1: transfer complete, registered.
- irq, out, 1: OR over channels of (IF[ch] & TCR[ch].IE), registered.

## Operation
- Register map, per channel at base ch*16:
  - +0x0 TCR: bit0 EN, bit1 CLR (self-clearing, reads 0), bit2 ONESHOT, bit3 IE.
  - +0x4 TCNT: read/write. A write loads the counter.
  - +0x8 PSC.
  - +0xC ARR.
- Shared status at NUM_CH*16: ISR. Bit ch is IF[ch]. Writing 1 clears the bit; writing 0 has no effect.
- Unmapped addresses read 0; writes to them are ignored.
- Reset values: all TCR/TCNT/PSC/IF = 0, ARR = all ones, PRDATA = 0, PREADY = 0, irq = 0.
- Prescaler: increments while EN=1. When pcnt == PSC, pcnt returns to 0 and tick pulses for 1 cycle. PSC=0 gives a tick every cycle; there is no PSC-1 underflow.
- Counter on tick:
  - If cnt == ARR: cnt returns to 0 and IF[ch] sets. If ONESHOT=1, EN clears.
  - Otherwise cnt+1.
- EN=0: prescaler and counter hold their values.
- CLR=1 (written): pcnt and cnt become 0 on the next edge, regardless of EN. The CLR bit itself is never stored.
- TCNT write: cnt takes the written value and pcnt becomes 0.
- Priority, highest first: PRESET > register write > CLR > tick.
  - A TCNT write on a tick cycle wins.
  - A TCR write wins over a same-cycle one-shot EN auto-clear.
- IF set on the same cycle as an ISR W1C of that bit: the set wins and the bit stays 1.
- ARR changed below the current cnt: the counter counts up to the 2^CNT_W wrap through 0, then matches ARR normally.

## Timing
- APB handshake:
  - Setup cycle: PSEL=1, PENABLE=0.
  - First access cycle (PSEL & PENABLE & !PREADY): the write commits or PRDATA is captured.
  - Next cycle: PREADY=1 for exactly 1 cycle. This gives one wait state; every transfer takes 3 cycles minimum.
- Each transfer acts once; W1C is never applied twice.
- PRDATA holds its value until the next read.
- Register write to effect: new values are used by the counting logic from the cycle after commit.
- Tick to cnt update: the tick is registered, so cnt changes 1 cycle after pcnt == PSC is reached.
- Period with EN held: (PSC+1)*(ARR+1) cycles between IF sets.
- IF set to irq: irq is high 1 cycle after IF sets, and low 1 cycle after IF clears or IE clears.
- PRESET mid-transfer: PREADY drops to 0 on the next edge, the pending write is discarded, and all state returns to reset values.

## Configuration
- TIMER_IRQ_EN:
  - Defined: IF flags, ISR, IE bit and irq are implemented as above.
  - Undefined: no IF storage, ISR reads 0, TCR bit3 reads 0, irq is tied 0. Counting and one-shot behaviour are unchanged.

## Structure
- Package apb_timer_pkg holds:
  - register offset constants (TCR/TCNT/PSC/ARR offsets, ISR base formula);
  - TCR bit index constants (EN, CLR, ONESHOT, IE);
  - a packed struct for a channel's control fields.
- Sub-module timer_channel: one per channel, generate loop. It contains the prescaler, counter, one-shot EN clear and the wrap pulse output.
- The top level holds the APB decode, register file, IF/ISR and irq logic.

## Test plan
- Reset defaults: after PRESET, read every register → TCR=0, TCNT=0, PSC=0, ARR=0xFFFFFFFF, ISR=0. PREADY is 0 except for 1 cycle per transfer.
- Periodic count, ch0: PSC=2, ARR=3, TCR=0x9 → cnt runs 0,1,2,3,0, each value held 3 cycles. IF[0] sets every 12 cycles and irq rises 1 cycle later. Writing ISR=0x1 drops irq.
- One-shot, ch1: PSC=0, ARR=4, TCR=0x5 → EN clears at the wrap and cnt stays 0. ch0 is unaffected. IF[1]=1.
- Load and clear: write TCNT=7 while running → next read returns ≥7. Write TCR with CLR|EN → cnt=0 and pcnt=0 the next cycle, and a TCR read shows CLR=0.
- Collisions:
  - ISR W1C on the same cycle as a wrap → IF stays 1.
  - TCNT write on a tick cycle → the loaded value wins.
- PRESET asserted during the access phase of a PSC write → PSC=0 and PREADY=0 afterwards. A build without TIMER_IRQ_EN keeps irq=0 throughout.
